// File: rtl/mem_port_sequencer.sv
// mem_port_sequencer
//
// Purpose:
//   This module sequences fetches and loads/stores for the single-port instruction/data RAM of the
//   multicycle CPU. It owns the program counter and shares the one RAM port between instruction
//   fetch and load/store. It also holds the fetched instruction in a buffer that load/store
//   traffic never touches.
//
// Parameters:
//   DATA_W      datapath / PC / instruction width
//   ADDR_W      RAM address width (must not exceed DATA_W)
//   RD_LATENCY  RAM read latency in cycles (1..4)
//   RESET_PC    PC value after reset
//
// Ports:
//   i_clk, i_reset             clock (rising edge), synchronous active-high reset
//   i_fetch_req                fetch the instruction at the current PC
//   o_fetch_done, o_instr      one-cycle fetch-complete pulse, instruction buffer
//   o_pc                       program counter
//   i_pc_update, i_pc_branch   advance PC: pc+pc_disp when branch, else pc+1
//   i_pc_disp                  signed displacement
//   i_ls_req, i_ls_we          load/store request, 1 = store
//   i_ls_addr, i_ls_wdata      load/store address and store data
//   o_ls_done, o_ls_rdata      one-cycle access-complete pulse, load data register
//   o_busy                     FSM not idle or a fetch is pending
//   o_mem_*, i_mem_rdata       RAM port
module mem_port_sequencer #(
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       ADDR_W     = 10,
  parameter int unsigned       RD_LATENCY = 1,
  parameter logic [DATA_W-1:0] RESET_PC   = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_fetch_req,
  output logic              o_fetch_done,
  output logic [DATA_W-1:0] o_instr,
  output logic [DATA_W-1:0] o_pc,
  input  logic              i_pc_update,
  input  logic              i_pc_branch,
  input  logic [DATA_W-1:0] i_pc_disp,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [DATA_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_wdata,
  output logic              o_ls_done,
  output logic [DATA_W-1:0] o_ls_rdata,
  output logic              o_busy,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int unsigned      CNT_W    = 3;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LATENCY);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFWait = 2'd1,
    StLWait = 2'd2,
    StSDone = 2'd3
  } state_e;

  state_e              r_state, w_state_d;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d;
  logic                r_pend, w_pend_d;
  logic [ADDR_W-1:0]   r_pend_addr, w_pend_addr_d;
  logic [DATA_W-1:0]   r_pc, w_pc_d;
  logic [DATA_W-1:0]   r_instr, w_instr_d;
  logic [DATA_W-1:0]   r_ls_rdata, w_ls_rdata_d;
  logic                r_fetch_done, w_fetch_done_d;
  logic                r_ls_done, w_ls_done_d;
  logic                r_busy, w_busy_d;
  logic                r_mem_en, w_mem_en_d;
  logic                r_mem_we, w_mem_we_d;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_d;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_d;

  logic                w_fetch_start;
  logic [ADDR_W-1:0]   w_fetch_addr;
  logic                w_unused_ls_addr;

  // Only the low ADDR_W bits of the load/store address reach the RAM.
  assign w_unused_ls_addr = ^i_ls_addr;

  // A pending fetch has priority over any new request in the cycle the load/store completes.
  // A plain fetch starts only when no load/store competes for the port.
  assign w_fetch_start = (r_state == StIdle) && (r_pend || (i_fetch_req && !i_ls_req));
  assign w_fetch_addr  = r_pend ? r_pend_addr : r_pc[ADDR_W-1:0];

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_pend_d       = r_pend;
    w_pend_addr_d  = r_pend_addr;
    w_instr_d      = r_instr;
    w_ls_rdata_d   = r_ls_rdata;
    w_fetch_done_d = 1'b0;
    w_ls_done_d    = 1'b0;
    w_mem_en_d     = 1'b0;
    w_mem_we_d     = 1'b0;
    w_mem_addr_d   = r_mem_addr;
    w_mem_wdata_d  = r_mem_wdata;

    case (r_state)
      StIdle: begin
        if (w_fetch_start) begin
          w_mem_en_d   = 1'b1;
          w_mem_addr_d = w_fetch_addr;
          w_cnt_d      = LAT_LOAD;
          w_pend_d     = 1'b0;
          w_state_d    = StFWait;
        end else if (i_ls_req) begin
          w_mem_en_d    = 1'b1;
          w_mem_we_d    = i_ls_we;
          w_mem_addr_d  = i_ls_addr[ADDR_W-1:0];
          w_mem_wdata_d = i_ls_wdata;
          w_cnt_d       = LAT_LOAD;
          w_state_d     = i_ls_we ? StSDone : StLWait;
          // The PC of the accept cycle is kept so the deferred fetch ignores later updates.
          if (i_fetch_req) begin
            w_pend_d      = 1'b1;
            w_pend_addr_d = r_pc[ADDR_W-1:0];
          end
        end
      end
      // The counter starts at RD_LATENCY in the strobe cycle and reaches zero in the cycle
      // where the RAM presents read data.
      StFWait: begin
        if (r_cnt == '0) begin
          w_instr_d      = i_mem_rdata;
          w_fetch_done_d = 1'b1;
          w_state_d      = StIdle;
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      StLWait: begin
        if (r_cnt == '0) begin
          w_ls_rdata_d = i_mem_rdata;
          w_ls_done_d  = 1'b1;
          w_state_d    = StIdle;
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      StSDone: begin
        w_ls_done_d = 1'b1;
        w_state_d   = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    w_busy_d = (w_state_d != StIdle) || w_pend_d;

    // The PC update is independent of the port FSM and wraps modulo 2^DATA_W.
    w_pc_d = r_pc;
    if (i_pc_update) begin
      w_pc_d = i_pc_branch ? (r_pc + i_pc_disp) : (r_pc + DATA_W'(1));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_pend       <= 1'b0;
      r_pend_addr  <= '0;
      r_pc         <= RESET_PC;
      r_instr      <= '0;
      r_ls_rdata   <= '0;
      r_fetch_done <= 1'b0;
      r_ls_done    <= 1'b0;
      r_busy       <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_pend       <= w_pend_d;
      r_pend_addr  <= w_pend_addr_d;
      r_pc         <= w_pc_d;
      r_instr      <= w_instr_d;
      r_ls_rdata   <= w_ls_rdata_d;
      r_fetch_done <= w_fetch_done_d;
      r_ls_done    <= w_ls_done_d;
      r_busy       <= w_busy_d;
      r_mem_en     <= w_mem_en_d;
      r_mem_we     <= w_mem_we_d;
      r_mem_addr   <= w_mem_addr_d;
      r_mem_wdata  <= w_mem_wdata_d;
    end
  end

  assign o_fetch_done = r_fetch_done;
  assign o_instr      = r_instr;
  assign o_pc         = r_pc;
  assign o_ls_done    = r_ls_done;
  assign o_ls_rdata   = r_ls_rdata;
  assign o_busy       = r_busy;
  assign o_mem_en     = r_mem_en;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer. The bench builds three instances with read latencies
// of 1, 3 and 4. Each instance has its own RAM model. An unwritten RAM word reads as
// 0x1234 + addr. Outside its valid cycle the read bus carries 0xDEAD, so a mistimed capture
// is visible.
module tb_mem_port_sequencer;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst, ram_clr, fetch_req, pc_update, pc_branch, ls_req, ls_we;
  logic [NI-1:0] fetch_done, ls_done, busy, mem_en, mem_we;
  logic [15:0]   pc_disp [NI];
  logic [15:0]   ls_addr [NI];
  logic [15:0]   ls_wdata [NI];
  logic [15:0]   instr [NI];
  logic [15:0]   pc [NI];
  logic [15:0]   ls_rdata [NI];
  logic [15:0]   mem_wdata [NI];
  logic [15:0]   mem_rdata [NI];
  logic [9:0]    mem_addr [NI];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

    mem_port_sequencer #(
      .DATA_W    (16),
      .ADDR_W    (10),
      .RD_LATENCY(L),
      .RESET_PC  (16'h0000)
    ) u_dut (
      .i_clk       (clk),
      .i_reset     (rst[g]),
      .i_fetch_req (fetch_req[g]),
      .o_fetch_done(fetch_done[g]),
      .o_instr     (instr[g]),
      .o_pc        (pc[g]),
      .i_pc_update (pc_update[g]),
      .i_pc_branch (pc_branch[g]),
      .i_pc_disp   (pc_disp[g]),
      .i_ls_req    (ls_req[g]),
      .i_ls_we     (ls_we[g]),
      .i_ls_addr   (ls_addr[g]),
      .i_ls_wdata  (ls_wdata[g]),
      .o_ls_done   (ls_done[g]),
      .o_ls_rdata  (ls_rdata[g]),
      .o_busy      (busy[g]),
      .o_mem_en    (mem_en[g]),
      .o_mem_we    (mem_we[g]),
      .o_mem_addr  (mem_addr[g]),
      .o_mem_wdata (mem_wdata[g]),
      .i_mem_rdata (mem_rdata[g])
    );

    logic [15:0]   ram [1024];
    logic [1023:0] wmask;
    logic [15:0]   pipe [L];

    always @(posedge clk) begin
      if (ram_clr[g]) wmask <= '0;
      if (mem_en[g] && mem_we[g]) begin
        ram[mem_addr[g]]   <= mem_wdata[g];
        wmask[mem_addr[g]] <= 1'b1;
      end
      if (mem_en[g] && !mem_we[g]) begin
        pipe[0] <= wmask[mem_addr[g]] ? ram[mem_addr[g]] : (16'h1234 + {6'b0, mem_addr[g]});
      end else begin
        pipe[0] <= 16'hDEAD;
      end
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end

    assign mem_rdata[g] = pipe[L-1];
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setpc(input int i, input logic [15:0] disp, input logic br);
    pc_update[i] = 1'b1;
    pc_branch[i] = br;
    pc_disp[i]   = disp;
    tick(1);
    pc_update[i] = 1'b0;
    pc_branch[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = '1;
    ram_clr   = '1;
    fetch_req = '0;
    pc_update = '0;
    pc_branch = '0;
    ls_req    = '0;
    ls_we     = '0;
    for (int i = 0; i < NI; i++) begin
      pc_disp[i]  = '0;
      ls_addr[i]  = '0;
      ls_wdata[i] = '0;
    end
    tick(2);

    // Reset state
    chk("rst_pc", 32'(pc[0]), 32'h0);
    chk("rst_instr", 32'(instr[0]), 32'h0);
    chk("rst_ls_rdata", 32'(ls_rdata[0]), 32'h0);
    chk("rst_fetch_done", 32'(fetch_done[0]), 32'h0);
    chk("rst_ls_done", 32'(ls_done[0]), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr[0]), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata[0]), 32'h0);
    rst     = '0;
    ram_clr = '0;
    tick(1);

    // T1: fetch at pc=0 with latency 1
    fetch_req[0] = 1'b1;
    tick(1);
    fetch_req[0] = 1'b0;
    chk("t1_c1_en", 32'(mem_en[0]), 32'h1);
    chk("t1_c1_addr", 32'(mem_addr[0]), 32'h0);
    chk("t1_c1_we", 32'(mem_we[0]), 32'h0);
    chk("t1_c1_busy", 32'(busy[0]), 32'h1);
    tick(1);
    chk("t1_c2_en", 32'(mem_en[0]), 32'h0);
    chk("t1_c2_done", 32'(fetch_done[0]), 32'h0);
    tick(1);
    chk("t1_c3_done", 32'(fetch_done[0]), 32'h1);
    chk("t1_c3_instr", 32'(instr[0]), 32'h1234);
    chk("t1_c3_busy", 32'(busy[0]), 32'h0);
    tick(1);
    chk("t1_c4_done", 32'(fetch_done[0]), 32'h0);

    // T2: store 0xBEEF to 0x005, then load it back with latency 3
    ls_req[1]   = 1'b1;
    ls_we[1]    = 1'b1;
    ls_addr[1]  = 16'h0005;
    ls_wdata[1] = 16'hBEEF;
    tick(1);
    ls_req[1] = 1'b0;
    ls_we[1]  = 1'b0;
    chk("t2_st_c1_en", 32'(mem_en[1]), 32'h1);
    chk("t2_st_c1_we", 32'(mem_we[1]), 32'h1);
    chk("t2_st_c1_addr", 32'(mem_addr[1]), 32'h005);
    chk("t2_st_c1_wdata", 32'(mem_wdata[1]), 32'hBEEF);
    chk("t2_st_c1_done", 32'(ls_done[1]), 32'h0);
    tick(1);
    chk("t2_st_c2_done", 32'(ls_done[1]), 32'h1);
    chk("t2_st_c2_we", 32'(mem_we[1]), 32'h0);
    chk("t2_st_c2_busy", 32'(busy[1]), 32'h0);
    ls_req[1]  = 1'b1;
    ls_we[1]   = 1'b0;
    ls_addr[1] = 16'h0005;
    tick(1);
    ls_req[1] = 1'b0;
    chk("t2_ld_c1_en", 32'(mem_en[1]), 32'h1);
    chk("t2_ld_c1_we", 32'(mem_we[1]), 32'h0);
    chk("t2_ld_c1_addr", 32'(mem_addr[1]), 32'h005);
    tick(3);
    chk("t2_ld_c4_done", 32'(ls_done[1]), 32'h0);
    chk("t2_ld_c4_we", 32'(mem_we[1]), 32'h0);
    tick(1);
    chk("t2_ld_c5_done", 32'(ls_done[1]), 32'h1);
    chk("t2_ld_c5_rdata", 32'(ls_rdata[1]), 32'hBEEF);
    chk("t2_ld_c5_instr", 32'(instr[1]), 32'h0);

    // T3: simultaneous fetch (pc=0x020) and load 0x010; load goes first
    setpc(0, 16'h0020, 1'b1);
    chk("t3_pc", 32'(pc[0]), 32'h0020);
    fetch_req[0] = 1'b1;
    ls_req[0]    = 1'b1;
    ls_we[0]     = 1'b0;
    ls_addr[0]   = 16'h0010;
    tick(1);
    fetch_req[0] = 1'b0;
    ls_req[0]    = 1'b0;
    chk("t3_c1_addr", 32'(mem_addr[0]), 32'h010);
    chk("t3_c1_busy", 32'(busy[0]), 32'h1);
    tick(1);
    chk("t3_c2_busy", 32'(busy[0]), 32'h1);
    chk("t3_c2_done", 32'(ls_done[0]), 32'h0);
    tick(1);
    chk("t3_c3_ls_done", 32'(ls_done[0]), 32'h1);
    chk("t3_c3_rdata", 32'(ls_rdata[0]), 32'h1244);
    chk("t3_c3_busy", 32'(busy[0]), 32'h1);
    chk("t3_c3_instr", 32'(instr[0]), 32'h1234);
    tick(1);
    chk("t3_c4_en", 32'(mem_en[0]), 32'h1);
    chk("t3_c4_addr", 32'(mem_addr[0]), 32'h020);
    chk("t3_c4_busy", 32'(busy[0]), 32'h1);
    tick(1);
    chk("t3_c5_busy", 32'(busy[0]), 32'h1);
    chk("t3_c5_done", 32'(fetch_done[0]), 32'h0);
    tick(1);
    chk("t3_c6_done", 32'(fetch_done[0]), 32'h1);
    chk("t3_c6_instr", 32'(instr[0]), 32'h1254);
    chk("t3_c6_busy", 32'(busy[0]), 32'h0);
    chk("t3_c6_rdata", 32'(ls_rdata[0]), 32'h1244);

    // T4: PC arithmetic and address wrap
    setpc(0, 16'hFFE5, 1'b1);
    chk("t4_pc_5", 32'(pc[0]), 32'h0005);
    setpc(0, 16'hFFFB, 1'b1);
    chk("t4_pc_neg", 32'(pc[0]), 32'h0000);
    setpc(0, 16'hFFFF, 1'b1);
    chk("t4_pc_ffff", 32'(pc[0]), 32'hFFFF);
    setpc(0, 16'h1234, 1'b0);
    chk("t4_pc_wrap", 32'(pc[0]), 32'h0000);
    setpc(0, 16'h0400, 1'b1);
    chk("t4_pc_400", 32'(pc[0]), 32'h0400);
    fetch_req[0] = 1'b1;
    tick(1);
    fetch_req[0] = 1'b0;
    chk("t4_c1_en", 32'(mem_en[0]), 32'h1);
    chk("t4_c1_addr", 32'(mem_addr[0]), 32'h000);
    tick(2);
    chk("t4_c3_done", 32'(fetch_done[0]), 32'h1);
    chk("t4_c3_instr", 32'(instr[0]), 32'h1234);

    // T5: pc_update coincident with fetch_req uses the pre-update PC
    setpc(0, 16'hFC07, 1'b1);
    chk("t5_pc_7", 32'(pc[0]), 32'h0007);
    fetch_req[0] = 1'b1;
    pc_update[0] = 1'b1;
    tick(1);
    fetch_req[0] = 1'b0;
    pc_update[0] = 1'b0;
    chk("t5_c1_addr", 32'(mem_addr[0]), 32'h007);
    chk("t5_c1_pc", 32'(pc[0]), 32'h0008);
    tick(2);
    chk("t5_c3_instr", 32'(instr[0]), 32'h123B);

    // T6: reset in cycle 2 of a latency-4 fetch
    fetch_req[2] = 1'b1;
    tick(1);
    fetch_req[2] = 1'b0;
    tick(5);
    chk("t6_pre_done", 32'(fetch_done[2]), 32'h1);
    chk("t6_pre_instr", 32'(instr[2]), 32'h1234);
    tick(1);
    setpc(2, 16'h0000, 1'b0);
    chk("t6_pc_1", 32'(pc[2]), 32'h0001);
    fetch_req[2] = 1'b1;
    tick(1);
    fetch_req[2] = 1'b0;
    chk("t6_c1_en", 32'(mem_en[2]), 32'h1);
    chk("t6_c1_addr", 32'(mem_addr[2]), 32'h001);
    tick(1);
    rst[2] = 1'b1;
    tick(1);
    rst[2] = 1'b0;
    chk("t6_rst_busy", 32'(busy[2]), 32'h0);
    chk("t6_rst_pc", 32'(pc[2]), 32'h0000);
    chk("t6_rst_instr", 32'(instr[2]), 32'h0);
    for (int c = 4; c <= 7; c++) begin
      tick(1);
      chk($sformatf("t6_c%0d_done", c), 32'(fetch_done[2]), 32'h0);
      chk($sformatf("t6_c%0d_instr", c), 32'(instr[2]), 32'h0);
    end
    fetch_req[2] = 1'b1;
    tick(1);
    fetch_req[2] = 1'b0;
    chk("t6_new_c1_en", 32'(mem_en[2]), 32'h1);
    chk("t6_new_c1_addr", 32'(mem_addr[2]), 32'h000);
    tick(4);
    chk("t6_new_c5_done", 32'(fetch_done[2]), 32'h0);
    tick(1);
    chk("t6_new_c6_done", 32'(fetch_done[2]), 32'h1);
    chk("t6_new_c6_instr", 32'(instr[2]), 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_sequencer.md
# mem_port_sequencer

Parametrised fetch and load/store sequencer for the single-port instruction/data RAM of the multicycle CPU. It owns the PC (with +1 or signed-displacement update), arbitrates the one RAM port between instruction fetch and load/store, and supports configurable read latency. It holds the fetched instruction in a buffer that load/store traffic never disturbs, so the control FSM sees a stable instruction throughout execute.

## Interface
- DATA_W, 16, datapath/PC/instruction width
- ADDR_W, 10, RAM address width; must be ≤ DATA_W
- RD_LATENCY, 1, RAM read latency in cycles (1..4)
- RESET_PC, 0, PC value after reset
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- fetch_req  in  1  request instruction fetch at current PC
- fetch_done  out  1  one-cycle pulse: instr updated
- instr  out  DATA_W  instruction buffer
- pc  out  DATA_W  program counter
- pc_update  in  1  advance PC this cycle
- pc_branch  in  1  with pc_update: 1 = pc+pc_disp, 0 = pc+1
- pc_disp  in  DATA_W  signed two's-complement displacement
- ls_req  in  1  request load/store
- ls_we  in  1  1 = store, 0 = load (sampled with ls_req)
- ls_addr  in  DATA_W  load/store address
- ls_wdata  in  DATA_W  store data
- ls_done  out  1  one-cycle pulse: access complete
- ls_rdata  out  DATA_W  load data register
- busy  out  1  state ≠ IDLE or fetch pending
- mem_en  out  1  RAM enable (one-cycle strobe)
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data

## Operation
- States: IDLE, F_WAIT (fetch read), L_WAIT (load read), S_DONE (store); RD_LATENCY down-counter.
- Requests sampled only in IDLE. Requests while busy are ignored.
- Fetch accept: latch pc[ADDR_W-1:0] as address → F_WAIT.
- ls_req accept: latch ls_addr[ADDR_W-1:0], ls_wdata, ls_we → L_WAIT (load) or S_DONE (store).
- fetch_req and ls_req in the same IDLE cycle: load/store is served first. The fetch is recorded as pending with the PC value of that cycle, and starts automatically in the ls_done cycle without a new request.
- Load/store never changes instr. Fetch never changes ls_rdata.
- pc_update is honoured in any state: pc ← pc+1 or pc+pc_disp, modulo 2^DATA_W. The fetch address is the pre-update PC when pc_update and fetch_req coincide.
- All outputs are registered.

## Timing
- Cycle 0 = accept cycle (request high in IDLE).
- Cycle 1: mem_en=1, mem_addr valid; mem_we=1 and mem_wdata valid for a store. mem_en/mem_we are low in all other cycles.
- Read: mem_rdata is captured at the end of cycle 1+RD_LATENCY. fetch_done/ls_done pulse in cycle 2+RD_LATENCY, with the new instr/ls_rdata visible in that same cycle. The FSM is back in IDLE in that cycle, so a new request can be accepted there.
- Store: ls_done pulses in cycle 2; FSM back in IDLE in cycle 2.
- Pending fetch after a load/store: its cycle 0 is the ls_done cycle.
- Throughput: one read per RD_LATENCY+2 cycles; one store per 2 cycles.
- Reset values: state IDLE, pending cleared, pc=RESET_PC, instr=0, ls_rdata=0, fetch_done=ls_done=busy=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation: the operation is aborted on the next edge, no done pulse is issued, and late mem_rdata is ignored.
- Address wrap: mem_addr uses the low ADDR_W bits only; pc 2^DATA_W−1 +1 → 0.

## Test plan
- Reset, then fetch_req at pc=0, RD_LATENCY=1, RAM[0]=0x1234 → mem_en in cycle 1 with addr 0; fetch_done in cycle 3 with instr=0x1234; busy low in cycle 3.
- Store ls_addr=0x005, ls_wdata=0xBEEF, then load 0x005 with RD_LATENCY=3 → mem_we only in the store's cycle 1; ls_done at store cycle 2 and load cycle 5; ls_rdata=0xBEEF; instr unchanged.
- fetch_req+ls_req (load 0x010) together with pc=0x020 → load first (ls_done cycle 3), then fetch of 0x020 accepted in cycle 3 with fetch_done in cycle 6; busy high in cycles 1–5.
- PC arithmetic (DATA_W=16): pc=0x0005, pc_branch, pc_disp=0xFFFB → pc=0x0000; pc=0xFFFF, pc_update → pc=0x0000; fetch with pc=0x0400 → mem_addr=0x000.
- pc_update coincident with fetch_req at pc=0x0007 → mem_addr=0x007, pc=0x0008 next cycle.
- reset asserted in cycle 2 of an RD_LATENCY=4 fetch → no fetch_done, instr=0, pc=RESET_PC, and a new fetch succeeds normally afterward.
